// File: rtl/rect_cfg_pkg.sv
// Shared types and constants for the rectangle configuration sequencer:
// FSM states, ASCII framing bytes, reply status codes and the bounds helper.
package rect_cfg_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DIGIT = 3'd1,
      S_TAIL  = 3'd2,
      S_CHECK = 3'd3,
      S_REPLY = 3'd4
   } state_e;

   localparam logic [7:0] ASC_DOLLAR = 8'h24;
   localparam logic [7:0] ASC_HASH   = 8'h23;
   localparam logic [7:0] ASC_0      = 8'h30;
   localparam logic [7:0] ASC_9      = 8'h39;
   localparam logic [7:0] ASC_K      = 8'h4B;
   localparam logic [7:0] ASC_E      = 8'h45;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_BADCHR  = 2'd1;
   localparam logic [1:0] ST_RANGE   = 2'd2;
   localparam logic [1:0] ST_TIMEOUT = 2'd3;

   // A span is usable when it is non-empty and ends inside the active area.
   function automatic logic span_ok(input logic [9:0] org, input logic [9:0] len,
                                    input logic [10:0] lim);
      logic [10:0] sum;
      sum = {1'b0, org} + {1'b0, len};
      return (len != 10'd0) && (sum <= lim);
   endfunction

endpackage

// File: rtl/rect_cfg_dec.sv
// Three-digit ASCII decimal accumulator: classifies the byte as a digit and
// presents acc*10 + digit so the caller can capture a finished field.
module rect_cfg_dec
   import rect_cfg_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       step_i,
   input  logic       last_i,
   input  logic [7:0] data_i,
   output logic       is_digit_o,
   output logic [9:0] val_o
);

   logic [9:0] acc_q;
   logic [9:0] acc_d;
   logic [7:0] digit_s;

   assign digit_s    = data_i - ASC_0;
   assign is_digit_o = (data_i >= ASC_0) && (data_i <= ASC_9);
   assign val_o      = (acc_q << 3) + (acc_q << 1) + {6'd0, digit_s[3:0]};

   // Next accumulator value; cleared after the third digit of a field.
   always_comb begin
      acc_d = acc_q;
      if (clr_i || (step_i && last_i)) begin
         acc_d = 10'd0;
      end else if (step_i) begin
         acc_d = val_o;
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= 10'd0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/rect_cfg_ctrl.sv
// Framed ASCII rectangle command sequencer: parses $XXXYYYWWWHHH#, validates,
// replies K/E over the UART and commits accepted geometry at frame_start.
module rect_cfg_ctrl
   import rect_cfg_pkg::*;
#(
   parameter int H_ACT       = 640,
   parameter int V_ACT       = 480,
   parameter int TIMEOUT_CYC = 52080
)(
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] pi_data,
   input  logic       pi_flag,
   input  logic       frame_start,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_flag,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic [9:0] w,
   output logic [9:0] h,
   output logic       cfg_valid,
   output logic [1:0] err
);

   localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

   state_e            state_q, state_d;
   logic [1:0]        field_q, field_d;
   logic [1:0]        pos_q, pos_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [3:0][9:0]   sh_q, sh_d;
   logic [3:0][9:0]   pg_q, pg_d;
   logic [3:0][9:0]   out_q, out_d;
   logic              pend_q, pend_d;
   logic              cfg_valid_q, cfg_valid_d;
   logic [1:0]        status_q, status_d;
   logic [1:0]        err_q, err_d;
   logic [7:0]        tx_data_q, tx_data_d;

   logic              dec_clr_s, dec_step_s, dec_last_s, is_digit_s;
   logic [9:0]        dec_val_s;
   logic              in_frame_s, timeout_s, accept_s, tx_flag_s;

   rect_cfg_dec u_dec (
      .clk_i      (sys_clk),
      .rst_i      (sys_rst),
      .clr_i      (dec_clr_s),
      .step_i     (dec_step_s),
      .last_i     (dec_last_s),
      .data_i     (pi_data),
      .is_digit_o (is_digit_s),
      .val_o      (dec_val_s)
   );

   assign in_frame_s = (state_q == S_DIGIT) || (state_q == S_TAIL);
   assign timeout_s  = in_frame_s && !pi_flag && (idle_q == IDLE_LAST);

   // Next-state, parsing, validation, reply and commit logic.
   always_comb begin
      state_d     = state_q;
      field_d     = field_q;
      pos_d       = pos_q;
      sh_d        = sh_q;
      pg_d        = pg_q;
      out_d       = out_q;
      pend_d      = pend_q;
      cfg_valid_d = 1'b0;
      status_d    = status_q;
      err_d       = err_q;
      tx_data_d   = tx_data_q;
      dec_clr_s   = 1'b0;
      dec_step_s  = 1'b0;
      dec_last_s  = 1'b0;
      accept_s    = 1'b0;
      tx_flag_s   = 1'b0;

      if (in_frame_s) begin
         idle_d = pi_flag ? '0 : idle_q + IDLE_W'(1);
      end else begin
         idle_d = '0;
      end

      case (state_q)
         S_IDLE: begin
            if (pi_flag && (pi_data == ASC_DOLLAR)) begin
               state_d   = S_DIGIT;
               field_d   = 2'd0;
               pos_d     = 2'd0;
               dec_clr_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DIGIT: begin
            if (pi_flag && (pi_data == ASC_DOLLAR)) begin
               field_d   = 2'd0;
               pos_d     = 2'd0;
               dec_clr_s = 1'b1;
            end else if (pi_flag && is_digit_s) begin
               dec_step_s = 1'b1;
               if (pos_q == 2'd2) begin
                  dec_last_s     = 1'b1;
                  sh_d[field_q]  = dec_val_s;
                  pos_d          = 2'd0;
                  field_d        = field_q + 2'd1;
                  state_d        = (field_q == 2'd3) ? S_TAIL : S_DIGIT;
               end else begin
                  pos_d = pos_q + 2'd1;
               end
            end else if (pi_flag) begin
               state_d   = S_REPLY;
               status_d  = ST_BADCHR;
               tx_data_d = ASC_E;
            end else if (timeout_s) begin
               state_d   = S_REPLY;
               status_d  = ST_TIMEOUT;
               tx_data_d = ASC_E;
            end else begin
               state_d = S_DIGIT;
            end
         end
         S_TAIL: begin
            if (pi_flag && (pi_data == ASC_HASH)) begin
               state_d = S_CHECK;
            end else if (pi_flag && (pi_data == ASC_DOLLAR)) begin
               state_d   = S_DIGIT;
               field_d   = 2'd0;
               pos_d     = 2'd0;
               dec_clr_s = 1'b1;
            end else if (pi_flag) begin
               state_d   = S_REPLY;
               status_d  = ST_BADCHR;
               tx_data_d = ASC_E;
            end else if (timeout_s) begin
               state_d   = S_REPLY;
               status_d  = ST_TIMEOUT;
               tx_data_d = ASC_E;
            end else begin
               state_d = S_TAIL;
            end
         end
         S_CHECK: begin
            state_d = S_REPLY;
            if (span_ok(sh_q[0], sh_q[2], 11'(H_ACT)) && span_ok(sh_q[1], sh_q[3], 11'(V_ACT))) begin
               status_d  = ST_OK;
               tx_data_d = ASC_K;
               pg_d      = sh_q;
               accept_s  = 1'b1;
            end else begin
               status_d  = ST_RANGE;
               tx_data_d = ASC_E;
            end
         end
         S_REPLY: begin
            if (!tx_busy) begin
               tx_flag_s = 1'b1;
               err_d     = status_q;
               state_d   = S_IDLE;
            end else begin
               state_d = S_REPLY;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Commit reads the pending registers as they were before this cycle.
      if (frame_start && pend_q) begin
         out_d       = pg_q;
         cfg_valid_d = 1'b1;
         pend_d      = 1'b0;
      end else begin
         out_d = out_q;
      end
      if (accept_s) begin
         pend_d = 1'b1;
      end else begin
         pend_d = pend_d;
      end
   end

   // State and datapath registers.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= S_IDLE;
         field_q     <= 2'd0;
         pos_q       <= 2'd0;
         idle_q      <= '0;
         sh_q        <= '0;
         pg_q        <= '0;
         out_q       <= '0;
         pend_q      <= 1'b0;
         cfg_valid_q <= 1'b0;
         status_q    <= ST_OK;
         err_q       <= ST_OK;
         tx_data_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         field_q     <= field_d;
         pos_q       <= pos_d;
         idle_q      <= idle_d;
         sh_q        <= sh_d;
         pg_q        <= pg_d;
         out_q       <= out_d;
         pend_q      <= pend_d;
         cfg_valid_q <= cfg_valid_d;
         status_q    <= status_d;
         err_q       <= err_d;
         tx_data_q   <= tx_data_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_flag   = tx_flag_s;
   assign x         = out_q[0];
   assign y         = out_q[1];
   assign w         = out_q[2];
   assign h         = out_q[3];
   assign cfg_valid = cfg_valid_q;
   assign err       = err_q;

endmodule

// File: tb/tb_rect_cfg_ctrl.sv
// Self-checking bench for rect_cfg_ctrl: directed plan cases plus random
// frames checked against a frame-level model of pending/committed geometry.
module tb_rect_cfg_ctrl;

   localparam int H  = 640;
   localparam int V  = 480;
   localparam int TO = 52080;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [7:0] pi_data;
   logic       pi_flag;
   logic       frame_start;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_flag;
   logic [9:0] x, y, w, h;
   logic       cfg_valid;
   logic [1:0] err;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int flag_cnt = 0;
   int flag_cyc = 0;
   logic [7:0] flag_data = 8'h00;
   int cfg_cnt = 0;

   int m_pend;
   int m_pg[4];
   int m_out[4];
   logic [7:0] frm[$];
   int stb[$];
   logic [7:0] bad_tab[6] = '{8'h41, 8'h7A, 8'h2F, 8'h3A, 8'h20, 8'h25};

   rect_cfg_ctrl dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .pi_data     (pi_data),
      .pi_flag     (pi_flag),
      .frame_start (frame_start),
      .tx_busy     (tx_busy),
      .tx_data     (tx_data),
      .tx_flag     (tx_flag),
      .x           (x),
      .y           (y),
      .w           (w),
      .h           (h),
      .cfg_valid   (cfg_valid),
      .err         (err)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (tx_flag === 1'b1) begin
         flag_cnt  = flag_cnt + 1;
         flag_cyc  = cyc;
         flag_data = tx_data;
      end
      if (cfg_valid === 1'b1) cfg_cnt = cfg_cnt + 1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time exhausted, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      pi_data = b;
      pi_flag = 1'b1;
      tick();
      pi_flag = 1'b0;
      pi_data = 8'h00;
   endtask

   task automatic send_seq(input int gap_max);
      stb.delete();
      foreach (frm[i]) begin
         stb.push_back(cyc);
         send_byte(frm[i]);
         if (gap_max > 0) ticks($urandom_range(0, gap_max));
      end
   endtask

   task automatic put3(input int n);
      frm.push_back(8'(48 + n / 100));
      frm.push_back(8'(48 + (n / 10) % 10));
      frm.push_back(8'(48 + n % 10));
   endtask

   task automatic build(input int a, input int b, input int c, input int d);
      frm.push_back(8'h24);
      put3(a); put3(b); put3(c); put3(d);
      frm.push_back(8'h23);
   endtask

   function automatic int exp_status(input int a, input int b, input int c, input int d);
      if (c == 0 || d == 0 || a + c > H || b + d > V) return 2;
      return 0;
   endfunction

   task automatic check_geo(input string tag, input int e[4]);
      check_eq({tag, ".x"}, x, e[0]);
      check_eq({tag, ".y"}, y, e[1]);
      check_eq({tag, ".w"}, w, e[2]);
      check_eq({tag, ".h"}, h, e[3]);
   endtask

   task automatic expect_reply(input string tag, input int base, input int code, input int exp_cyc);
      for (int i = 0; i < 200 && flag_cnt == base; i++) tick();
      ticks(2);
      check_eq({tag, "_nflag"}, flag_cnt - base, 1);
      check_eq({tag, "_data"}, flag_data, (code == 0) ? 8'h4B : 8'h45);
      check_eq({tag, "_cyc"}, flag_cyc, exp_cyc);
      check_eq({tag, "_err"}, err, code);
   endtask

   task automatic model_accept(input int a, input int b, input int c, input int d);
      if (exp_status(a, b, c, d) == 0) begin
         m_pend = 1;
         m_pg   = '{a, b, c, d};
      end
   endtask

   // Sends frm (already built), expects a reply for geometry a..d.
   task automatic run_built(input string tag, input int a, input int b, input int c, input int d,
                            input int gap);
      int base;
      base = flag_cnt;
      send_seq(gap);
      expect_reply(tag, base, exp_status(a, b, c, d), stb[stb.size() - 1] + 2);
      model_accept(a, b, c, d);
      check_geo({tag, "_hold"}, m_out);
   endtask

   task automatic run_frame(input string tag, input int a, input int b, input int c, input int d,
                            input int gap);
      frm.delete();
      build(a, b, c, d);
      run_built(tag, a, b, c, d, gap);
   endtask

   task automatic do_fs(input string tag);
      int base;
      int was;
      int e[4];
      base = cfg_cnt;
      was  = m_pend;
      if (m_pend != 0) e = m_pg;
      else             e = m_out;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check_eq({tag, "_cv"}, cfg_valid, was);
      check_geo(tag, e);
      m_out  = e;
      m_pend = 0;
      tick();
      check_eq({tag, "_cvcnt"}, cfg_cnt - base, was);
   endtask

   task automatic rand_geo(output int a, output int b, output int c, output int d, input int wild);
      if (wild != 0) begin
         a = $urandom_range(0, 999);
         b = $urandom_range(0, 600);
         c = $urandom_range(0, 700);
         d = $urandom_range(0, 500);
      end else begin
         a = $urandom_range(0, H - 1);
         c = $urandom_range(1, H - a);
         b = $urandom_range(0, V - 1);
         d = $urandom_range(1, V - b);
      end
   endtask

   initial begin
      int a, b, c, d, base, t, p, kind, k;
      m_pend  = 0;
      m_pg    = '{0, 0, 0, 0};
      m_out   = '{0, 0, 0, 0};
      sys_rst = 1'b1;
      pi_data = 8'h00;
      pi_flag = 1'b0;
      frame_start = 1'b0;
      tx_busy = 1'b0;
      ticks(3);
      check_geo("reset", m_out);
      check_eq("reset.cfg_valid", cfg_valid, 0);
      check_eq("reset.err", err, 0);
      check_eq("reset.tx_flag", tx_flag, 0);
      check_eq("reset.tx_data", tx_data, 0);
      sys_rst = 1'b0;
      ticks(2);

      // Valid frame, committed only at frame_start.
      run_frame("valid", 100, 50, 200, 150, 0);
      ticks(5);
      check_geo("valid_prefs", m_out);
      do_fs("valid_fs");
      do_fs("valid_fs_none");

      // Range error leaves pending and outputs untouched.
      run_frame("range", 500, 0, 200, 100, 1);
      do_fs("range_fs");

      // Bad character, trailing digits ignored, then recovery.
      frm.delete();
      frm = '{8'h24, 8'h31, 8'h41, 8'h30, 8'h35, 8'h30, 8'h32, 8'h30, 8'h30,
              8'h31, 8'h35, 8'h30, 8'h23};
      base = flag_cnt;
      send_seq(0);
      expect_reply("badchr", base, 1, stb[2] + 1);
      run_frame("recover", 10, 20, 30, 40, 2);
      do_fs("recover_fs");

      // Timeout mid-frame.
      frm.delete();
      frm = '{8'h24, 8'h31, 8'h32, 8'h33, 8'h34};
      base = flag_cnt;
      send_seq(0);
      t = stb[4];
      ticks(TO - 2);
      check_eq("timeout_early", flag_cnt - base, 0);
      for (int i = 0; i < 10 && flag_cnt == base; i++) tick();
      ticks(2);
      check_eq("timeout_nflag", flag_cnt - base, 1);
      check_eq("timeout_when", (flag_cyc >= t + TO) && (flag_cyc <= t + TO + 1), 1);
      check_eq("timeout_data", flag_data, 8'h45);
      check_eq("timeout_err", err, 3);

      // Restart inside a frame.
      frm.delete();
      frm = '{8'h24, 8'h31, 8'h32};
      build(0, 0, 10, 10);
      run_built("restart", 0, 0, 10, 10, 0);
      do_fs("restart_fs");

      // Backpressure: reply waits for tx_busy to drop, exactly one strobe.
      tx_busy = 1'b1;
      frm.delete();
      build(1, 2, 3, 4);
      base = flag_cnt;
      send_seq(0);
      ticks(99);
      check_eq("busy_hold", flag_cnt - base, 0);
      tx_busy = 1'b0;
      expect_reply("busy", base, 0, cyc);
      model_accept(1, 2, 3, 4);
      ticks(5);
      check_eq("busy_once", flag_cnt - base, 1);

      // Overwrite: second frame wins.
      run_frame("ovw1", 5, 6, 7, 8, 1);
      run_frame("ovw2", 300, 200, 100, 50, 1);
      do_fs("ovw_fs");

      // Acceptance in the same cycle as frame_start.
      run_frame("raceA", 11, 22, 33, 44, 0);
      frm.delete();
      build(55, 66, 77, 88);
      frm.pop_back();
      base = flag_cnt;
      send_seq(0);
      t = cyc;
      send_byte(8'h23);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check_eq("race_cv", cfg_valid, 1);
      check_geo("race_old", m_pg);
      m_out = m_pg;
      m_pend = 0;
      expect_reply("raceB", base, 0, t + 2);
      model_accept(55, 66, 77, 88);
      check_geo("race_hold", m_out);
      do_fs("race_fs2");

      // Reset in the middle of a frame with a frame pending.
      run_frame("pre_rst", 40, 30, 20, 10, 0);
      frm.delete();
      frm = '{8'h24, 8'h31, 8'h32};
      send_seq(0);
      sys_rst = 1'b1;
      #2;
      m_pend = 0;
      m_out  = '{0, 0, 0, 0};
      check_geo("rst_mid", m_out);
      check_eq("rst_mid.err", err, 0);
      tick();
      sys_rst = 1'b0;
      tick();
      do_fs("rst_fs");

      // Randomized frames.
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         frm.delete();
         if (kind == 2) begin
            rand_geo(a, b, c, d, 0);
            build(a, b, c, d);
            p = $urandom_range(1, 13);
            frm[p] = bad_tab[$urandom_range(0, 5)];
            base = flag_cnt;
            send_seq(3);
            expect_reply("rnd_bad", base, 1, stb[p] + 1);
         end else begin
            rand_geo(a, b, c, d, (kind == 1) ? 1 : 0);
            if (kind == 3) begin
               k = $urandom_range(0, 12);
               frm.push_back(8'h24);
               for (int j = 0; j < k; j++) frm.push_back(8'(48 + $urandom_range(0, 9)));
            end
            build(a, b, c, d);
            run_built("rnd", a, b, c, d, 3);
         end
         if ($urandom_range(0, 2) == 0) do_fs("rnd_fs");
      end
      do_fs("final_fs");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
